kernel_avg_acc: RTL and testbench

Sequential accumulate-and-average unit for the kernel-calculation control unit: the additive counterpart of the 16-bit subtraction datapath. It accepts a stream of unsigned 16-bit pixel samples over a valid/ready handshake, sums one kernel window of 2^LOG2K samples, and emits the full-width window sum plus the rounded mean for the downsampled output pixel. One window is produced per 2^LOG2K accepted samples, with output back-pressure.

---
 rtl/kernel_avg_acc.sv | 88 ++++++++
 tb/tb_kernel_avg_acc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/kernel_avg_acc.sv
// Accumulate-and-average unit: sums one window of 2^LOG2K unsigned samples and
// holds the exact sum plus the rounded mean until downstream accepts them.
module kernel_avg_acc #(
    parameter int W     = 16,
    parameter int LOG2K = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W+LOG2K-1:0]   out_sum,
    output logic [W-1:0]         out_avg,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SW = W + LOG2K;
    localparam logic [LOG2K-1:0] LAST = LOG2K'((1 << LOG2K) - 1);
    localparam logic [SW:0]      HALF = (SW + 1)'(1 << (LOG2K - 1));

    typedef enum logic {ACC, HOLD} state_t;

    state_t           state;
    logic [SW-1:0]    acc;
    logic [LOG2K-1:0] cnt;
    logic [SW-1:0]    next_sum;
    logic [SW:0]      rounded;
    logic             take;
    logic             unused_bits;

    assign take     = in_valid && in_ready;
    assign next_sum = acc + SW'(in_data);
    // One extra bit so the rounding constant can never wrap the window sum.
    assign rounded  = {1'b0, next_sum} + HALF;
    assign unused_bits = ^{rounded[SW], rounded[LOG2K-1:0]};

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    if (clr) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (take) begin
                        if (cnt == LAST) begin
                            out_sum   <= next_sum;
                            out_avg   <= rounded[SW-1:LOG2K];
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc <= next_sum;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // clr is deliberately ignored here so a finished result is never lost.
                    if (out_ready) begin
                        state     <= ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACC;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_avg_acc.sv
// Self-checking bench for kernel_avg_acc: a queue-based window model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_kernel_avg_acc;

    localparam int W     = 16;
    localparam int LOG2K = 2;
    localparam int K     = 1 << LOG2K;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clr = 1'b0;
    logic [W-1:0]         in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [W+LOG2K-1:0]   out_sum;
    logic [W-1:0]         out_avg;
    logic                 out_valid;
    logic                 out_ready = 1'b0;

    int checks = 0;
    int fails  = 0;

    kernel_avg_acc #(.W(W), .LOG2K(LOG2K)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_sum(out_sum), .out_avg(out_avg),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a window is just the list of accepted samples; once it
    // holds K of them the result is their sum and the rounded quotient.
    int     win[$];
    bit     pending  = 1'b0;
    longint exp_sum  = 0;
    longint exp_avg  = 0;
    bit     started  = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            win.delete();
            pending = 1'b0;
            exp_sum = 0;
            exp_avg = 0;
        end else if (!pending) begin
            if (clr) begin
                win.delete();
            end else if (in_valid) begin
                win.push_back(int'(in_data));
                if (win.size() == K) begin
                    exp_sum = 0;
                    foreach (win[i]) exp_sum += win[i];
                    exp_avg = (exp_sum + K / 2) / K;
                    pending = 1'b1;
                    win.delete();
                end
            end
        end else if (out_ready) begin
            pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready",  longint'(in_ready),  longint'(!pending));
            check("out_valid", longint'(out_valid), longint'(pending));
            check("out_sum",   longint'(out_sum),   exp_sum);
            check("out_avg",   longint'(out_avg),   exp_avg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = W'(v);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", longint'(out_valid), 0);
        check("rst_sum",   longint'(out_sum),   0);
        check("rst_avg",   longint'(out_avg),   0);
        rst = 1'b0;
        tick();
        check("rel_in_ready", longint'(in_ready), 1);

        // Basic window
        out_ready = 1'b1;
        send(10); send(20); send(30); send(41);
        check("basic_valid", longint'(out_valid), 1);
        check("basic_sum",   longint'(out_sum),   101);
        check("basic_avg",   longint'(out_avg),   25);
        check("basic_busy",  longint'(in_ready),  0);
        tick();
        check("basic_ready", longint'(in_ready),  1);
        check("basic_done",  longint'(out_valid), 0);

        // Maximum values, then rounding of a small sum
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        check("max_sum", longint'(out_sum), 18'h3FFFC);
        check("max_avg", longint'(out_avg), 16'hFFFF);
        tick();
        send(1); send(1); send(1); send(0);
        check("rnd_sum", longint'(out_sum), 3);
        check("rnd_avg", longint'(out_avg), 1);
        tick();

        // Back-pressure: samples offered during HOLD must not be counted
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(100);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", longint'(out_valid), 1);
            check("bp_sum",   longint'(out_sum),   400);
            check("bp_avg",   longint'(out_avg),   100);
            check("bp_ready", longint'(in_ready),  0);
            in_valid = 1'b1;
            in_data  = 16'd999;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", longint'(out_valid), 0);
        check("bp_in_ready", longint'(in_ready), 1);

        // Gaps and clr: 5 and 6 discarded, 7 dropped
        send(5);
        tick();
        send(6);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd7;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        send(1); send(2); send(3); send(4);
        check("clr_sum", longint'(out_sum), 10);
        check("clr_avg", longint'(out_avg), 3);
        tick();

        // Reset mid-window
        send(9); send(9); send(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(8);
        check("mid_rst_sum", longint'(out_sum), 32);
        check("mid_rst_avg", longint'(out_avg), 8);
        tick();

        // Reset during HOLD: result is discarded
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(50);
        check("hold_valid", longint'(out_valid), 1);
        rst = 1'b1;
        tick();
        check("hold_rst_valid", longint'(out_valid), 0);
        check("hold_rst_sum",   longint'(out_sum),   0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("hold_rst_idle", longint'(out_valid), 0);
        check("hold_rst_ready", longint'(in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
